// File: rtl/shift_reg_seq_if.sv
// Control/data bundle for the sequenced universal shift register.
interface shift_reg_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             ld;
    logic [WIDTH-1:0] D;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             sin;
    logic [WIDTH-1:0] Q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output ld, D, start, mode, amount, sin,
        input  Q, sout, busy, done
    );

    modport slave (
        input  ld, D, start, mode, amount, sin,
        output Q, sout, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// Sequenced universal shift register: parallel load plus eight 1-bit-per-clock
// shift modes under a start/busy/done handshake.
module shift_reg_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    shift_reg_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ld pre-empts start in IDLE; the counter hitting 1 marks the final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.ld && bus.start) begin
                    state_d = (bus.amount == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered Moore outputs.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ld) begin
                    q_d = bus.D;
                end else if (bus.start) begin
                    mode_d = bus.mode;
                    cnt_d  = bus.amount;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                case (mode_q)
                    3'b000: begin
                        q_d    = q_q;
                        sout_d = sout_q;
                    end
                    3'b001: begin
                        q_d    = {q_q[WIDTH-2:0], 1'b0};
                        sout_d = q_q[WIDTH-1];
                    end
                    3'b010: begin
                        q_d    = {1'b0, q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                    3'b011: begin
                        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        sout_d = q_q[WIDTH-1];
                    end
                    3'b100: begin
                        q_d    = {q_q[0], q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                    3'b101: begin
                        q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                    3'b110: begin
                        q_d    = {q_q[WIDTH-2:0], bus.sin};
                        sout_d = q_q[WIDTH-1];
                    end
                    default: begin
                        q_d    = {bus.sin, q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                endcase
            end
            default: begin
                q_d = q_q;
            end
        endcase
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            sout_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= 3'b000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq against a behavioural shift model.
module tb_shift_reg_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [W-1:0] m_q;
    logic         m_sout;

    shift_reg_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_reg_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One step of the reference model; returns {sout, Q}.
    function automatic logic [W:0] model_step(input logic [W-1:0] q, input logic [2:0] md,
                                              input logic s, input logic so);
        logic [W-1:0] qn;
        logic         sn;
        case (md)
            3'd0: begin qn = q;                                sn = so;     end
            3'd1: begin qn = q << 1;                           sn = q[W-1]; end
            3'd2: begin qn = q >> 1;                           sn = q[0];   end
            3'd3: begin qn = (q << 1) | (q >> (W-1));          sn = q[W-1]; end
            3'd4: begin qn = (q >> 1) | (q << (W-1));          sn = q[0];   end
            3'd5: begin qn = W'($signed(q) >>> 1);             sn = q[0];   end
            3'd6: begin qn = (q << 1) | W'(s);                 sn = q[W-1]; end
            default: begin qn = (q >> 1) | (W'(s) << (W-1));   sn = q[0];   end
        endcase
        return {sn, qn};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if (bus.Q !== 8'h00 || bus.sout !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: Q=%h sout=%b busy=%b done=%b, want 00/0/0/0",
                     bus.Q, bus.sout, bus.busy, bus.done);
        end
        m_q = '0;
        m_sout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        @(negedge clk);
        bus.ld = 1'b1; bus.D = 8'hA5;
        @(posedge clk); #1;
        m_q = 8'hA5;
        n_vec++;
        if (bus.Q !== 8'hA5 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 1'b0) begin
            n_err++;
            $display("FAIL load: Q=%h busy=%b done=%b sout=%b, want a5/0/0/0",
                     bus.Q, bus.busy, bus.done, bus.sout);
        end
        @(negedge clk);
        bus.ld = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] pre [5]  = '{8'hA5, 8'h81, 8'hA5, 8'h00, 8'h0F};
        logic [2:0]   md  [5]  = '{3'd1, 3'd5, 3'd4, 3'd6, 3'd2};
        int           amt [5]  = '{3, 2, 8, 4, 9};
        logic [W-1:0] fq  [5]  = '{8'h28, 8'hE0, 8'hA5, 8'h0F, 8'h00};
        logic         fs  [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W:0]   r;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.ld = 1'b1; bus.D = pre[i]; bus.start = 1'b0;
            @(posedge clk); #1;
            m_q = pre[i];
            @(negedge clk);
            bus.ld = 1'b0; bus.start = 1'b1; bus.mode = md[i];
            bus.amount = CW'(amt[i]); bus.sin = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.Q !== m_q) begin
                n_err++;
                $display("FAIL dir%0d_start: busy=%b done=%b Q=%h, want 1/0/%h",
                         i, bus.busy, bus.done, bus.Q, m_q);
            end
            for (int k = 1; k <= amt[i]; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                r = model_step(m_q, md[i], 1'b1, m_sout);
                {m_sout, m_q} = r;
                @(posedge clk); #1;
                n_vec++;
                if (bus.Q !== m_q || bus.sout !== m_sout || bus.busy !== (k < amt[i])
                    || bus.done !== (k == amt[i])) begin
                    n_err++;
                    $display("FAIL dir%0d_step%0d: Q=%h sout=%b busy=%b done=%b, want %h/%b/%b/%b",
                             i, k, bus.Q, bus.sout, bus.busy, bus.done, m_q, m_sout,
                             k < amt[i], k == amt[i]);
                end
            end
            n_vec++;
            if (bus.Q !== fq[i] || bus.sout !== fs[i]) begin
                n_err++;
                $display("FAIL dir%0d_final: Q=%h sout=%b, want %h/%b", i, bus.Q, bus.sout, fq[i], fs[i]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_idle: busy=%b done=%b, want 0/0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_zero_amount();
        @(negedge clk);
        bus.ld = 1'b1; bus.D = 8'h3C;
        @(posedge clk); #1;
        m_q = 8'h3C;
        @(negedge clk);
        bus.ld = 1'b0; bus.start = 1'b1; bus.mode = 3'd1; bus.amount = '0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.Q !== m_q || bus.sout !== m_sout) begin
            n_err++;
            $display("FAIL zero_amt: done=%b busy=%b Q=%h sout=%b, want 1/0/%h/%b",
                     bus.done, bus.busy, bus.Q, bus.sout, m_q, m_sout);
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== m_q) begin
            n_err++;
            $display("FAIL zero_amt_idle: done=%b busy=%b Q=%h, want 0/0/%h",
                     bus.done, bus.busy, bus.Q, m_q);
        end
    endtask

    task automatic test_ld_priority();
        @(negedge clk);
        bus.ld = 1'b1; bus.D = 8'h5A; bus.start = 1'b1; bus.mode = 3'd1; bus.amount = CW'(3);
        @(posedge clk); #1;
        m_q = 8'h5A;
        n_vec++;
        if (bus.Q !== m_q || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL ld_prio: Q=%h busy=%b done=%b, want %h/0/0", bus.Q, bus.busy, bus.done, m_q);
        end
        @(negedge clk);
        bus.ld = 1'b0; bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.Q !== m_q || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL ld_prio_noseq%0d: Q=%h busy=%b done=%b, want %h/0/0",
                         k, bus.Q, bus.busy, bus.done, m_q);
            end
        end
    endtask

    task automatic test_ld_in_shift();
        logic [W:0] r;
        @(negedge clk);
        bus.ld = 1'b1; bus.D = 8'h81;
        @(posedge clk); #1;
        m_q = 8'h81;
        @(negedge clk);
        bus.ld = 1'b0; bus.start = 1'b1; bus.mode = 3'd1; bus.amount = CW'(4);
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.ld = 1'b1; bus.D = 8'hFF;
            r = model_step(m_q, 3'd1, 1'b0, m_sout);
            {m_sout, m_q} = r;
            @(posedge clk); #1;
        end
        n_vec++;
        if (bus.Q !== 8'h10 || bus.sout !== 1'b0 || bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL ld_in_shift: Q=%h sout=%b done=%b, want 10/0/1", bus.Q, bus.sout, bus.done);
        end
        @(negedge clk);
        bus.ld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.ld = 1'b1; bus.D = 8'hA5;
        @(posedge clk); #1;
        @(negedge clk);
        bus.ld = 1'b0; bus.start = 1'b1; bus.mode = 3'd3; bus.amount = CW'(6);
        @(posedge clk); #1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        m_q = '0;
        m_sout = 1'b0;
        n_vec++;
        if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: Q=%h busy=%b done=%b sout=%b, want 00/0/0/0",
                     bus.Q, bus.busy, bus.done, bus.sout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== 8'h00) begin
                n_err++;
                $display("FAIL reset_mid_after%0d: done=%b busy=%b Q=%h, want 0/0/00",
                         k, bus.done, bus.busy, bus.Q);
            end
        end
    endtask

    task automatic test_random();
        logic [W:0]   r;
        logic [2:0]   md;
        int           amt;
        logic         s;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                bus.ld = 1'b1; bus.D = W'($urandom); bus.start = 1'b0;
                @(posedge clk); #1;
                m_q = bus.D;
            end
            md  = 3'($urandom);
            amt = int'($urandom_range(15, 0));
            @(negedge clk);
            bus.ld = 1'b0; bus.start = 1'b1; bus.mode = md; bus.amount = CW'(amt);
            @(posedge clk); #1;
            n_vec++;
            if (bus.busy !== (amt != 0) || bus.done !== (amt == 0) || bus.Q !== m_q) begin
                n_err++;
                $display("FAIL rnd%0d_start: busy=%b done=%b Q=%h, want %b/%b/%h",
                         i, bus.busy, bus.done, bus.Q, amt != 0, amt == 0, m_q);
            end
            for (int k = 1; k <= amt; k++) begin
                @(negedge clk);
                s = 1'($urandom);
                bus.sin = s;
                bus.ld = 1'($urandom); bus.D = W'($urandom); bus.start = 1'($urandom);
                bus.mode = 3'($urandom); bus.amount = CW'($urandom);
                r = model_step(m_q, md, s, m_sout);
                {m_sout, m_q} = r;
                @(posedge clk); #1;
                n_vec++;
                if (bus.Q !== m_q || bus.sout !== m_sout || bus.busy !== (k < amt)
                    || bus.done !== (k == amt)) begin
                    n_err++;
                    $display("FAIL rnd%0d_step%0d md=%0d: Q=%h sout=%b busy=%b done=%b, want %h/%b/%b/%b",
                             i, k, md, bus.Q, bus.sout, bus.busy, bus.done, m_q, m_sout,
                             k < amt, k == amt);
                end
            end
            @(negedge clk);
            bus.ld = 1'($urandom); bus.D = W'($urandom); bus.start = 1'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q !== m_q || bus.sout !== m_sout) begin
                n_err++;
                $display("FAIL rnd%0d_idle: busy=%b done=%b Q=%h sout=%b, want 0/0/%h/%b",
                         i, bus.busy, bus.done, bus.Q, bus.sout, m_q, m_sout);
            end
        end
        @(negedge clk);
        bus.ld = 1'b0; bus.start = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_vec = 0;
        n_err = 0;
        m_q = '0;
        m_sout = 1'b0;
        bus.ld = 1'b0; bus.D = '0; bus.start = 1'b0;
        bus.mode = 3'd0; bus.amount = '0; bus.sin = 1'b0;
        test_reset();
        test_load();
        test_directed();
        test_zero_amount();
        test_ld_priority();
        test_ld_in_shift();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
